// File: rtl/hazard_stall_controller_pkg.sv
// Shared state encoding and counter width for the hazard/stall controller.
package hazard_stall_controller_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] IDLE_ENC     = 2'd0;
  localparam logic [1:0] MEM_WAIT_ENC = 2'd1;
  localparam logic [1:0] MEM_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = IDLE_ENC,
    MEM_WAIT = MEM_WAIT_ENC,
    MEM_DONE = MEM_DONE_ENC
  } state_t;

endpackage

// File: rtl/hazard_stall_controller_stall_counter.sv
// Saturating stall-cycle counter; clear wins over increment.
module stall_counter
  import hazard_stall_controller_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use stall, branch flush and multi-cycle memory freeze.
// state    | meaning
// IDLE     | no memory access outstanding
// MEM_WAIT | access started, pipeline frozen until mem_ack_i
// MEM_DONE | access complete, completed instruction advances one cycle
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       IF_ID_RegisterRs1_i,
  input  logic [4:0]       IF_ID_RegisterRs2_i,
  input  logic [4:0]       ID_EX_RegisterRd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             clear_cnt_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Flush_o,
  output logic             Pipe_Stall_o,
  output logic             mem_start_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_t r_state;
  state_t w_next_state;
  logic   w_freeze;
  logic   w_load_use;
  logic   w_rd_match;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (mem_req_i) w_next_state = MEM_WAIT;
      MEM_WAIT: if (mem_ack_i) w_next_state = MEM_DONE;
      MEM_DONE: w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Freeze includes the ack cycle; MEM_DONE deliberately ignores a still-held mem_req_i.
  assign w_freeze   = ((r_state == IDLE) && mem_req_i) || (r_state == MEM_WAIT);
  assign w_rd_match = (ID_EX_RegisterRd_i == IF_ID_RegisterRs1_i) ||
                      (ID_EX_RegisterRd_i == IF_ID_RegisterRs2_i);
  assign w_load_use = ID_EX_MemRead_i && (ID_EX_RegisterRd_i != 5'd0) && w_rd_match && !w_freeze;

  assign PCWrite_o     = !(w_freeze || w_load_use);
  assign IF_ID_Write_o = !(w_freeze || w_load_use);
  assign ID_EX_Flush_o = w_load_use;
  assign Pipe_Stall_o  = w_freeze;
  assign IF_ID_Flush_o = branch_taken_i && !w_freeze && !w_load_use;
  assign mem_start_o   = (r_state == IDLE) && mem_req_i;
  assign busy_o        = (r_state != IDLE);

  stall_counter u_stall_counter (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_freeze || w_load_use),
    .i_clr (clear_cnt_i),
    .o_cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: driver predicts each cycle's outputs from a behavioural model, monitor compares.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memread = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        branch = 1'b0, req = 1'b0, ack = 1'b0, clr = 1'b0;
  logic        pcw, ifidw, ifidf, idexf, stall, start, busy;
  logic [15:0] cnt;

  hazard_stall_controller dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .ID_EX_MemRead_i     (memread),
    .IF_ID_RegisterRs1_i (rs1),
    .IF_ID_RegisterRs2_i (rs2),
    .ID_EX_RegisterRd_i  (rd),
    .branch_taken_i      (branch),
    .mem_req_i           (req),
    .mem_ack_i           (ack),
    .clear_cnt_i         (clr),
    .PCWrite_o           (pcw),
    .IF_ID_Write_o       (ifidw),
    .IF_ID_Flush_o       (ifidf),
    .ID_EX_Flush_o       (idexf),
    .Pipe_Stall_o        (stall),
    .mem_start_o         (start),
    .busy_o              (busy),
    .stall_cnt_o         (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  flags;   // pcw, ifidw, ifidf, idexf, stall, start, busy
    logic [15:0] count;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   obs_starts = 0;
  int   obs_stalls = 0;

  // Model: an access is "outstanding" from acceptance until its ack; the cycle after ack is "released".
  bit   m_outstanding = 0;
  bit   m_released    = 0;
  int   m_count       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("cycle_outputs", {9'd0, pcw, ifidw, ifidf, idexf, stall, start, busy, cnt},
            {9'd0, e.flags, e.count});
      if (start) obs_starts++;
      if (stall) obs_stalls++;
    end
  end

  task automatic drive_cycle(input bit i_mr, input int i_rs1, input int i_rs2, input int i_rd,
                             input bit i_br, input bit i_req, input bit i_ack, input bit i_clr);
    bit   frz, lu, new_acc;
    exp_t e;
    @(posedge clk);
    #1;
    memread = i_mr; rs1 = 5'(i_rs1); rs2 = 5'(i_rs2); rd = 5'(i_rd);
    branch = i_br; req = i_req; ack = i_ack; clr = i_clr;
    new_acc = !m_outstanding && !m_released && i_req;
    frz = m_outstanding || new_acc;
    lu  = i_mr && (i_rd != 0) && (i_rd == i_rs1 || i_rd == i_rs2) && !frz;
    e.flags = {!(frz || lu), !(frz || lu), i_br && !frz && !lu, lu, frz, new_acc,
               m_outstanding || m_released};
    e.count = 16'(m_count);
    q.push_back(e);
    if (m_outstanding) begin
      if (i_ack) begin m_outstanding = 0; m_released = 1; end
    end else if (m_released) begin
      m_released = 0;
    end else if (i_req) begin
      m_outstanding = 1;
    end
    if (i_clr) m_count = 0;
    else if ((frz || lu) && m_count < 65535) m_count++;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; memread = 0; rs1 = 0; rs2 = 0; rd = 0;
    branch = 0; req = 0; ack = 0; clr = 0;
    #1;
    check("reset_async_busy", busy, 0);
    check("reset_async_cnt", cnt, 0);
    check("reset_outputs", {pcw, ifidw, ifidf, idexf, stall, start}, 6'b110000);
    @(posedge clk);
    #1;
    rst = 0;
    m_outstanding = 0; m_released = 0; m_count = 0;
  endtask

  initial begin
    rst = 1;
    #2;
    check("por_cnt", cnt, 0);
    check("por_busy", busy, 0);
    @(posedge clk); #1; rst = 0;
    do_reset();

    // load-use on Rs1, then x0 destination never stalls
    idle_cycle();
    drive_cycle(1, 5, 7, 5, 0, 0, 0, 0);
    idle_cycle();
    drain();
    check("load_use_cnt", cnt, 1);
    drive_cycle(1, 3, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    drain();
    check("x0_cnt_unchanged", cnt, 1);

    // miss with ack four cycles after start, req held into the release cycle
    obs_starts = 0; obs_stalls = 0;
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    idle_cycle();
    drain();
    check("miss_starts", obs_starts, 1);
    check("miss_stall_cycles", obs_stalls, 5);
    check("miss_back_idle", busy, 0);

    // memory request, load-use and branch together: only the freeze shows
    drive_cycle(1, 9, 1, 9, 1, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    drain();

    // reset in the middle of an access, then a fresh start
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    drain();
    check("mid_access_busy", busy, 1);
    do_reset();
    obs_starts = 0;
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    drain();
    check("restart_start_pulse", obs_starts, 1);

    // randomized traffic honouring the request-hold protocol
    for (int n = 0; n < 1500; n++) begin
      bit r_req, r_ack;
      if (m_outstanding)   r_req = 1;
      else if (m_released) r_req = 1'($urandom_range(0, 1));
      else                 r_req = ($urandom_range(0, 4) == 0);
      r_ack = m_outstanding ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 3) == 0), r_req, r_ack,
                  ($urandom_range(0, 31) == 0));
    end
    drive_cycle(0, 0, 0, 0, 0, m_outstanding, m_outstanding, 0);
    idle_cycle();
    idle_cycle();
    drain();

    // saturation then clear
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (70000) drive_cycle(1, 4, 2, 4, 0, 0, 0, 0);
    drain();
    check("saturated", cnt, 16'hFFFF);
    drive_cycle(1, 4, 2, 4, 0, 0, 0, 1);
    idle_cycle();
    drain();
    check("cleared", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ID_EX_MemRead_i, input, 1, a load is in EX.
REQ-004 SHALL have port IF_ID_RegisterRs1_i, input, 5, ID source register 1.
REQ-005 SHALL have port IF_ID_RegisterRs2_i, input, 5, ID source register 2.
REQ-006 SHALL have port ID_EX_RegisterRd_i, input, 5, EX destination register.
REQ-007 SHALL have port branch_taken_i, input, 1, branch resolved taken in ID.
REQ-008 SHALL have port mem_req_i, input, 1, MEM-stage instruction needs a multi-cycle memory access; held until the pipeline advances.
REQ-009 SHALL have port mem_ack_i, input, 1, memory access complete; single-cycle pulse.
REQ-010 SHALL have port clear_cnt_i, input, 1, synchronous clear of the stall counter.
REQ-011 SHALL have port PCWrite_o, output, 1, PC update enable.
REQ-012 SHALL have port IF_ID_Write_o, output, 1, IF/ID register write enable.
REQ-013 SHALL have port IF_ID_Flush_o, output, 1, zero the IF/ID register.
REQ-014 SHALL have port ID_EX_Flush_o, output, 1, insert a bubble into ID/EX.
REQ-015 SHALL have port Pipe_Stall_o, output, 1, freeze ID/EX, EX/MEM and MEM/WB.
REQ-016 SHALL have port mem_start_o, output, 1, one-cycle memory start pulse.
REQ-017 SHALL have port busy_o, output, 1, FSM not in IDLE.
REQ-018 SHALL have port stall_cnt_o, output, 16, count of stalled cycles.

Function
REQ-019 SHALL implement the FSM states IDLE, MEM_WAIT and MEM_DONE.
REQ-020 SHALL take these transitions: IDLE->MEM_WAIT on mem_req_i; MEM_WAIT->MEM_DONE on mem_ack_i; MEM_DONE->IDLE unconditionally; MEM_WAIT holds otherwise.
REQ-021 SHALL define freeze = (IDLE & mem_req_i) | MEM_WAIT, including the cycle in which mem_ack_i is high.
REQ-022 SHALL ignore mem_req_i in MEM_DONE, so that the completed instruction advances exactly one cycle.
REQ-023 SHALL define load_use = ID_EX_MemRead_i & (Rd != 0) & (Rd == Rs1 | Rd == Rs2) & ~freeze.
REQ-024 SHALL drive PCWrite_o = IF_ID_Write_o = ~(freeze | load_use).
REQ-025 SHALL drive ID_EX_Flush_o = load_use.
REQ-026 SHALL drive Pipe_Stall_o = freeze.
REQ-027 SHALL drive IF_ID_Flush_o = branch_taken_i & ~freeze & ~load_use; a branch coinciding with a stall waits until the stall is released.
REQ-028 SHALL drive mem_start_o = IDLE & mem_req_i, so it is high for exactly one cycle per access.
REQ-029 SHALL apply the priority freeze > load_use > branch flush.
REQ-030 SHALL generate all outputs combinationally from the state and the inputs, with zero latency.
REQ-031 SHALL increment stall_cnt_o in each cycle with freeze | load_use, saturating at 0xFFFF (no wrap).
REQ-032 SHALL give clear_cnt_i priority over increment, so the counter reads 0 in the next cycle.
REQ-033 SHALL ignore mem_ack_i in IDLE and MEM_DONE, treating a spurious ack as a no-op.

Reset
REQ-034 SHALL force, on rst_i, state IDLE, stall_cnt_o = 0 and busy_o = 0, immediately and independent of clk_i.
REQ-035 SHALL, while rst_i is high with all inputs low, drive PCWrite_o = 1, IF_ID_Write_o = 1 and all other outputs 0.
REQ-036 SHALL abandon a pending access when rst_i is asserted mid-MEM_WAIT, and SHALL not emit mem_start_o again until mem_req_i is seen in IDLE.

Structure
REQ-037 SHALL place the state encoding (2-bit localparams IDLE = 0, MEM_WAIT = 1, MEM_DONE = 2) and the counter width (16) in a shared package.
REQ-038 SHALL implement the saturating counter as one sub-module, stall_counter, with enable, clear and asynchronous reset.
REQ-039 SHALL contain no other sub-modules; the hazard compare is inline.

Verification
REQ-040 SHALL cover load-use: MemRead = 1, Rd = 5, Rs1 = 5 -> PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1 for 1 cycle, and the counter goes 0->1.
REQ-041 SHALL cover x0: MemRead = 1, Rd = 0, Rs2 = 0 -> no stall, PCWrite = 1, counter unchanged.
REQ-042 SHALL cover a memory miss: mem_req high, ack 4 cycles after start -> mem_start pulses once, Pipe_Stall = 1 for 5 cycles, then MEM_DONE with Pipe_Stall = 0 while mem_req is still high, then IDLE.
REQ-043 SHALL cover simultaneous events: mem_req, load-use and branch_taken in the same cycle -> only Pipe_Stall = 1; ID_EX_Flush = 0 and IF_ID_Flush = 0.
REQ-044 SHALL cover reset mid-operation: rst_i pulsed during MEM_WAIT -> IDLE, counter 0, busy 0, and a new mem_req yields a fresh mem_start.
REQ-045 SHALL cover saturation: hold a stall for 70000 cycles -> counter reads 0xFFFF; clear_cnt_i -> counter reads 0 next cycle.
